capture_sequencer: RTL

//  Sequences RF sample collection between the data generator (ADC or test

---
 rtl/capture_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/capture_sequencer.sv
// capture_sequencer: moves RF samples from the data generator (ADC or test
// pattern) into the USB sample FIFO. Latches the test-mode select while idle,
// waits a settle period, then streams one zero-extended 10-bit sample per
// clock. Raises sticky flags for FIFO overflow and for breaks in the
// incrementing test pattern. Every output comes straight from a flop.
module capture_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,  // clocks spent in SETTLE, >= 1
  parameter int unsigned COUNT_WIDTH   = 32   // width of sampleCount
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   collectionEnable,
  input  logic                   testModeRequest,
  input  logic [9:0]             dataIn,
  input  logic                   fifoFull,
  output logic                   testModeFlag,
  output logic                   fifoWrite,
  output logic [15:0]            fifoData,
  output logic                   captureActive,
  output logic                   bufferOverflow,
  output logic                   sequenceError,
  output logic [COUNT_WIDTH-1:0] sampleCount
);

  // The settle counter runs 0 .. SETTLE_CYCLES-1, one step per SETTLE clock.
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]    SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [9:0]             SAMPLE_ONE  = 10'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_OVERFLOW
  } state_e;

  state_e                 state_q,          state_d;
  logic [SETTLE_W-1:0]    settle_cnt_q,     settle_cnt_d;
  logic                   test_mode_q,      test_mode_d;
  logic                   fifo_write_q,     fifo_write_d;
  logic [15:0]            fifo_data_q,      fifo_data_d;
  logic                   capture_active_q, capture_active_d;
  logic                   overflow_q,       overflow_d;
  logic                   seq_err_q,        seq_err_d;
  logic [COUNT_WIDTH-1:0] sample_count_q,   sample_count_d;
  logic [9:0]             last_sample_q,    last_sample_d;
  logic                   have_last_q,      have_last_d;

  // Successor of the previous test-pattern word; 10-bit arithmetic makes
  // 1023 -> 0 a legal step.
  logic [9:0] expected_sample;
  assign expected_sample = last_sample_q + SAMPLE_ONE;

  // Next-state and next-output logic for the capture FSM.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d          = state_q;
    settle_cnt_d     = settle_cnt_q;
    test_mode_d      = test_mode_q;
    fifo_write_d     = 1'b0;
    fifo_data_d      = fifo_data_q;
    capture_active_d = 1'b0;
    overflow_d       = overflow_q;
    seq_err_d        = seq_err_q;
    sample_count_d   = sample_count_q;
    last_sample_d    = last_sample_q;
    have_last_d      = have_last_q;

    unique case (state_q)
      S_IDLE: begin
        // Test-mode select only follows the host while idle.
        test_mode_d = testModeRequest;
        if (collectionEnable) begin
          state_d        = S_SETTLE;
          settle_cnt_d   = '0;
          sample_count_d = '0;
          overflow_d     = 1'b0;
          seq_err_d      = 1'b0;
          have_last_d    = 1'b0;
        end
      end

      S_SETTLE: begin
        if (!collectionEnable) begin
          state_d = S_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d          = S_CAPTURE;
          capture_active_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_ONE;
        end
      end

      S_CAPTURE: begin
        // Host stop outranks a full FIFO, which outranks a write.
        if (!collectionEnable) begin
          state_d = S_IDLE;
        end else if (fifoFull) begin
          state_d    = S_OVERFLOW;
          overflow_d = 1'b1;
        end else begin
          capture_active_d = 1'b1;
          fifo_write_d     = 1'b1;
          fifo_data_d      = {6'b0, dataIn};
          sample_count_d   = sample_count_q + COUNT_ONE;
          if (test_mode_q) begin
            if (have_last_q && (dataIn != expected_sample)) begin
              seq_err_d = 1'b1;
            end
            last_sample_d = dataIn;
            have_last_d   = 1'b1;
          end
        end
      end

      S_OVERFLOW: begin
        // Parked until the host drops enable and restarts the capture.
        if (!collectionEnable) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      settle_cnt_q     <= '0;
      test_mode_q      <= 1'b0;
      fifo_write_q     <= 1'b0;
      fifo_data_q      <= '0;
      capture_active_q <= 1'b0;
      overflow_q       <= 1'b0;
      seq_err_q        <= 1'b0;
      sample_count_q   <= '0;
      last_sample_q    <= '0;
      have_last_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      test_mode_q      <= test_mode_d;
      fifo_write_q     <= fifo_write_d;
      fifo_data_q      <= fifo_data_d;
      capture_active_q <= capture_active_d;
      overflow_q       <= overflow_d;
      seq_err_q        <= seq_err_d;
      sample_count_q   <= sample_count_d;
      last_sample_q    <= last_sample_d;
      have_last_q      <= have_last_d;
    end
  end

  assign testModeFlag   = test_mode_q;
  assign fifoWrite      = fifo_write_q;
  assign fifoData       = fifo_data_q;
  assign captureActive  = capture_active_q;
  assign bufferOverflow = overflow_q;
  assign sequenceError  = seq_err_q;
  assign sampleCount    = sample_count_q;

endmodule
